// File: rtl/mem_mapper_pkg.sv
// Shared constants, lock-state encoding and register-map helpers for mem_mapper.
package mem_mapper_pkg;

  // Unlock key sequence written to the KEY register
  localparam logic [7:0] KEY1_VAL = 8'h55;
  localparam logic [7:0] KEY2_VAL = 8'hAA;

  // Encoding is visible to software through the KEY register read
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    KEY1     = 2'd2
  } lock_state_t;

  // STATUS register bit positions
  localparam int ST_FAULT_BIT  = 7;
  localparam int ST_LOCKED_BIT = 6;
  localparam int ST_FWIN_LSB   = 0;
  localparam int ST_FWIN_W     = 3;

  // Register offsets: windows occupy pairs, STATUS and KEY follow the last window
  function automatic int tag_ra(input int i);
    return 2 * i;
  endfunction

  function automatic int ctrl_ra(input int i);
    return 2 * i + 1;
  endfunction

  function automatic int status_ra(input int num_win);
    return 2 * num_win;
  endfunction

  function automatic int key_ra(input int num_win);
    return 2 * num_win + 1;
  endfunction

endpackage

// File: rtl/mem_mapper_win.sv
// One mapping window: page tag, enable and write-protect registers plus tag match.
module mem_mapper_win #(
  parameter int                   PAGE_BITS = 5,
  parameter logic [PAGE_BITS-1:0] RST_TAG   = '0,
  parameter logic                 RST_EN    = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 tag_we,
  input  logic                 ctrl_we,
  input  logic [PAGE_BITS-1:0] tag_d,
  input  logic [1:0]           ctrl_d,
  input  logic [PAGE_BITS-1:0] page,
  output logic [PAGE_BITS-1:0] tag,
  output logic                 en,
  output logic                 wp,
  output logic                 match
);

  // Window configuration registers, written only when the top grants access
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tag <= RST_TAG;
      en  <= RST_EN;
      wp  <= 1'b0;
    end else begin
      if (tag_we)  tag      <= tag_d;
      if (ctrl_we) {wp, en} <= ctrl_d;
    end
  end

  assign match = en & (tag == page);

endmodule

// File: rtl/mem_mapper.sv
// Programmable page mapper: NUM_WIN windows, priority hit encoding, write
// protection with a latched fault, and a key-sequence lock on configuration.
module mem_mapper
  import mem_mapper_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int PAGE_BITS = 5,
  parameter int NUM_WIN   = 4,
  parameter int RA_W      = $clog2(2 * NUM_WIN + 2),
  localparam int IDX_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
  localparam int OFF_W    = ADDR_W - PAGE_BITS
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   cs,
  input  logic [RA_W-1:0]        ra,
  input  logic                   rw,
  input  logic [7:0]             di,
  output logic [7:0]             dout,
  input  logic [ADDR_W-1:0]      addr,
  output logic [NUM_WIN-1:0]     win_hit,
  output logic                   any_hit,
  output logic [IDX_W+OFF_W-1:0] phys_addr,
  output logic                   mem_we,
  output logic                   intr
);

  logic [PAGE_BITS-1:0] page;
  logic [PAGE_BITS-1:0] tag_vec [NUM_WIN];
  logic [NUM_WIN-1:0]   en_vec;
  logic [NUM_WIN-1:0]   wp_vec;
  logic [NUM_WIN-1:0]   match_vec;
  logic [IDX_W-1:0]     win_idx;
  logic                 wp_hit;
  logic                 fault_now;
  logic                 wr_any;
  logic                 cfg_wr;
  logic                 status_clr;
  lock_state_t          lock_state;
  logic                 fault;
  logic [IDX_W-1:0]     fwin;
  logic [7:0]           status_byte;

  assign page       = addr[ADDR_W-1 -: PAGE_BITS];
  assign wr_any     = cs & ~rw;
  assign cfg_wr     = wr_any & (lock_state == UNLOCKED);
  assign status_clr = wr_any & (int'(ra) == status_ra(NUM_WIN)) & di[ST_FAULT_BIT];

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    mem_mapper_win #(
      .PAGE_BITS (PAGE_BITS),
      .RST_TAG   (PAGE_BITS'(g + 1)),
      .RST_EN    (g < 2)
    ) u_win (
      .CLK     (CLK),
      .RESET   (RESET),
      .tag_we  (cfg_wr && (int'(ra) == tag_ra(g))),
      .ctrl_we (cfg_wr && (int'(ra) == ctrl_ra(g))),
      .tag_d   (di[7 -: PAGE_BITS]),
      .ctrl_d  (di[1:0]),
      .page    (page),
      .tag     (tag_vec[g]),
      .en      (en_vec[g]),
      .wp      (wp_vec[g]),
      .match   (match_vec[g])
    );
  end

  // Priority encoder: scan high to low so the lowest matching window wins
  always_comb begin
    win_hit = '0;
    win_idx = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        win_hit    = '0;
        win_hit[i] = 1'b1;
        win_idx    = IDX_W'(i);
      end
    end
  end

  assign any_hit   = |win_hit;
  assign wp_hit    = |(win_hit & wp_vec);
  assign mem_we    = ~rw & any_hit & ~wp_hit;
  assign fault_now = ~rw & any_hit & wp_hit;
  assign phys_addr = {win_idx, addr[OFF_W-1:0]};
  assign intr      = fault;

  // Lock FSM: any key write locks, 55 then AA unlocks, config writes in KEY1 relock
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_state <= UNLOCKED;
    end else if (wr_any) begin
      if (int'(ra) == key_ra(NUM_WIN)) begin
        case (lock_state)
          UNLOCKED: lock_state <= LOCKED;
          LOCKED:   lock_state <= (di == KEY1_VAL) ? KEY1 : LOCKED;
          KEY1:     lock_state <= (di == KEY2_VAL) ? UNLOCKED : LOCKED;
          default:  lock_state <= LOCKED;
        endcase
      end else if ((int'(ra) < status_ra(NUM_WIN)) && (lock_state == KEY1)) begin
        lock_state <= LOCKED;
      end
    end
  end

  // Fault latch: first fault sticks; a new fault beats a same-edge clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fault <= 1'b0;
      fwin  <= '0;
    end else if (fault_now && (!fault || status_clr)) begin
      fault <= 1'b1;
      fwin  <= win_idx;
    end else if (status_clr) begin
      fault <= 1'b0;
      fwin  <= '0;
    end
  end

  // STATUS byte assembly
  always_comb begin
    status_byte                                  = '0;
    status_byte[ST_FAULT_BIT]                    = fault;
    status_byte[ST_LOCKED_BIT]                   = (lock_state != UNLOCKED);
    status_byte[ST_FWIN_LSB +: ST_FWIN_W]        = ST_FWIN_W'(fwin);
  end

  // Register read mux; unmapped offsets and deselected reads return FF
  always_comb begin
    dout = 8'hFF;
    if (cs) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (int'(ra) == tag_ra(i))  dout = 8'(tag_vec[i]) << (8 - PAGE_BITS);
        if (int'(ra) == ctrl_ra(i)) dout = {6'b0, wp_vec[i], en_vec[i]};
      end
      if (int'(ra) == status_ra(NUM_WIN)) dout = status_byte;
      if (int'(ra) == key_ra(NUM_WIN))    dout = {6'b0, lock_state};
    end
  end

endmodule
